// File: rtl/sha_if_pkg.sv
// rtl/sha_if_pkg.sv - sha256 register map, status bits and digest streamer state encoding
package sha_if_pkg;

  localparam logic [7:0] ADDR_CTRL    = 8'h08;
  localparam logic [7:0] ADDR_STATUS  = 8'h09;
  localparam logic [7:0] ADDR_BLOCK0  = 8'h10;
  localparam logic [7:0] ADDR_DIGEST0 = 8'h20;

  localparam int STATUS_READY_BIT = 0;
  localparam int STATUS_VALID_BIT = 1;

  localparam int DIGEST_WORDS = 8;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_POLL   = 3'd1,
    S_READ   = 3'd2,
    S_SEND   = 3'd3,
    S_HOLD   = 3'd4,
    S_WAITTX = 3'd5,
    S_FIN    = 3'd6
  } stream_state_t;

endpackage

// File: rtl/sha_digest_streamer_if.sv
// rtl/sha_digest_streamer_if.sv - sha256 register bus and uart_tx byte handshake
interface sha_digest_streamer_if;
  import sha_if_pkg::*;

  logic        sha_cs;
  logic        sha_we;
  logic [7:0]  sha_address;
  logic [31:0] sha_write_data;
  logic [31:0] sha_read_data;
  logic        sha_error;
  logic [7:0]  tx_data;
  logic        tx_send;
  logic        tx_ready;

  modport master (
    output sha_cs, sha_we, sha_address, sha_write_data, tx_data, tx_send,
    input  sha_read_data, sha_error, tx_ready
  );

  modport slave (
    input  sha_cs, sha_we, sha_address, sha_write_data, tx_data, tx_send,
    output sha_read_data, sha_error, tx_ready
  );

endinterface

// File: rtl/sha_digest_streamer.sv
// rtl/sha_digest_streamer.sv - polls sha256 for digest_valid, reads 8 digest words, streams 32 bytes MSB first
module sha_digest_streamer
  import sha_if_pkg::*;
#(
  parameter int POLL_TIMEOUT = 1_000_000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  sha_digest_streamer_if.master bus
);

  localparam int PW = $clog2(POLL_TIMEOUT + 1);
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_TIMEOUT - 1);

  stream_state_t state;
  logic [PW-1:0] poll_cnt;
  logic [2:0]    word_cnt;
  logic [1:0]    byte_cnt;
  logic [31:0]   shift;
  logic [7:0]    last_tx;
  logic          cs_q;
  logic [7:0]    addr_q;
  logic          send_now;

  // The send strobe must coincide with the cycle tx_ready is seen, so it is decoded from state.
  assign send_now           = (state == S_SEND) && bus.tx_ready;
  assign bus.tx_send        = send_now;
  assign bus.tx_data        = send_now ? shift[31:24] : last_tx;
  assign bus.sha_cs         = cs_q;
  assign bus.sha_address    = addr_q;
  assign bus.sha_we         = 1'b0;
  assign bus.sha_write_data = 32'h0;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      cs_q     <= 1'b0;
      addr_q   <= 8'h00;
      poll_cnt <= '0;
      word_cnt <= 3'd0;
      byte_cnt <= 2'd0;
      shift    <= 32'h0;
      last_tx  <= 8'h00;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_POLL;
            busy     <= 1'b1;
            cs_q     <= 1'b1;
            addr_q   <= ADDR_STATUS;
            poll_cnt <= '0;
          end
        end
        S_POLL: begin
          if (bus.sha_error) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            err   <= 1'b1;
            cs_q  <= 1'b0;
          end else if (bus.sha_read_data[STATUS_VALID_BIT]) begin
            state    <= S_READ;
            word_cnt <= 3'd0;
            addr_q   <= ADDR_DIGEST0;
          end else if (poll_cnt == POLL_LAST) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            err   <= 1'b1;
            cs_q  <= 1'b0;
          end else begin
            poll_cnt <= poll_cnt + 1'b1;
          end
        end
        S_READ: begin
          cs_q <= 1'b0;
          if (bus.sha_error) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            err   <= 1'b1;
          end else begin
            state    <= S_SEND;
            shift    <= bus.sha_read_data;
            byte_cnt <= 2'd0;
          end
        end
        S_SEND: begin
          if (bus.tx_ready) begin
            state   <= S_HOLD;
            last_tx <= shift[31:24];
            shift   <= {shift[23:0], 8'h00};
          end
        end
        // uart_tx may take one cycle to drop tx_ready after a send.
        S_HOLD: state <= S_WAITTX;
        S_WAITTX: begin
          if (bus.tx_ready) begin
            if (byte_cnt != 2'd3) begin
              byte_cnt <= byte_cnt + 2'd1;
              state    <= S_SEND;
            end else if (word_cnt != 3'd7) begin
              word_cnt <= word_cnt + 3'd1;
              addr_q   <= ADDR_DIGEST0 + {5'd0, word_cnt} + 8'd1;
              cs_q     <= 1'b1;
              state    <= S_READ;
            end else begin
              done  <= 1'b1;
              state <= S_FIN;
            end
          end
        end
        S_FIN: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          cs_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha_digest_streamer.sv
// tb/tb_sha_digest_streamer.sv - bench for sha_digest_streamer with sha256 and uart_tx behavioural models
module tb_sha_digest_streamer;
  import sha_if_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic busy, done, err;

  sha_digest_streamer_if bus ();

  sha_digest_streamer #(.POLL_TIMEOUT(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .bus     (bus.master)
  );

  always #5 clk = ~clk;

  // SHA-256("abc")
  logic [31:0] digest [8] = '{32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
                              32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};

  int errors = 0;
  int checks = 0;

  int valid_after = 0;
  int err_word = -1;
  int hold = 0;
  logic [31:0] stat_idle = 32'h0;
  int poll_base = 0;
  int dig_base = 0;
  int poll_count = 0;
  int dig_count = 0;
  int hold_cnt = 0;
  logic ready_q = 1'b1;

  logic [7:0] dig_off;
  assign dig_off = bus.sha_address - ADDR_DIGEST0;
  assign bus.tx_ready = ready_q;

  always_comb begin
    bus.sha_read_data = 32'h0;
    bus.sha_error     = 1'b0;
    if (bus.sha_cs) begin
      if (bus.sha_address == ADDR_STATUS) begin
        bus.sha_read_data = ((poll_count - poll_base) >= valid_after) ? 32'h2 : stat_idle;
      end else if (dig_off < 8'd8) begin
        bus.sha_read_data = digest[dig_off[2:0]];
        bus.sha_error     = (int'(dig_off) == err_word);
      end
    end
  end

  always @(posedge clk) begin
    if (bus.sha_cs && bus.sha_address == ADDR_STATUS) poll_count <= poll_count + 1;
    if (bus.sha_cs && dig_off < 8'd8) dig_count <= dig_count + 1;
    if (bus.tx_send && hold > 0) begin
      ready_q  <= 1'b0;
      hold_cnt <= hold;
    end else if (hold_cnt > 0) begin
      hold_cnt <= hold_cnt - 1;
      if (hold_cnt == 1) ready_q <= 1'b1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  function automatic logic [7:0] exp_byte(input int k);
    logic [31:0] w;
    w = digest[k / 4];
    return 8'((w >> (8 * (3 - (k % 4)))) & 32'hff);
  endfunction

  // Compare process: stream order, handshake rules and reset values.
  int cycle = 0;
  int exp_idx = 0;
  int n_done = 0;
  int n_err = 0;
  int start_cycle = 0;
  int first_send = -1;
  int last_send = 0;
  int done_cycle = 0;
  logic [7:0] first_byte = 8'h00;
  logic [7:0] last_byte = 8'h00;
  logic prev_send = 1'b0;
  logic rst_seen = 1'b0;

  always @(negedge clk) begin
    cycle++;
    if (rst_seen) begin
      chk("reset_outputs", {busy, done, err, bus.sha_cs, bus.tx_send, bus.sha_address, bus.tx_data}, 64'h0);
      last_byte = 8'h00;
    end
    rst_seen = !reset_n;
    if (reset_n) begin
      if (start && !busy) begin
        exp_idx = 0; n_done = 0; n_err = 0; start_cycle = cycle; first_send = -1;
      end
      chk("sha_we_wdata", {bus.sha_we, bus.sha_write_data}, 64'h0);
      if (bus.tx_send) begin
        chk("send_when_ready", bus.tx_ready, 1);
        chk("send_single_cycle", prev_send, 0);
        chk("byte_in_range", exp_idx < 32, 1);
        if (exp_idx < 32) chk("tx_byte", bus.tx_data, exp_byte(exp_idx));
        if (exp_idx == 0) begin first_send = cycle; first_byte = bus.tx_data; end
        last_send = cycle;
        last_byte = bus.tx_data;
        exp_idx++;
      end else begin
        chk("tx_data_hold", bus.tx_data, last_byte);
      end
      if (!busy) chk("cs_idle", bus.sha_cs, 0);
      if (done) begin n_done++; done_cycle = cycle; end
      if (err) n_err++;
      prev_send = bus.tx_send;
    end else begin
      prev_send = 1'b0;
    end
  end

  task automatic run(input int va, input logic [31:0] si, input int hd, input int ew, input int extra_start);
    valid_after = va; stat_idle = si; hold = hd; err_word = ew;
    poll_base = poll_count; dig_base = dig_count;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int i = 0; i < 20000 && (n_done + n_err) == 0; i++) begin
      @(negedge clk);
      if (i == extra_start) start = 1'b1;
      else start = 1'b0;
    end
    start = 1'b0;
    chk("run_finished", n_done + n_err, 1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // abc digest, valid on first poll, uart always ready
    run(0, 32'h0, 0, -1, -1);
    chk("t1_bytes", exp_idx, 32);
    chk("t1_done", n_done, 1);
    chk("t1_err", n_err, 0);
    chk("t1_status_reads", poll_count - poll_base, 1);
    chk("t1_digest_reads", dig_count - dig_base, 8);
    chk("t1_latency", first_send - start_cycle, 3);
    chk("t1_done_after_last", done_cycle - last_send, 3);
    chk("t1_first_byte", first_byte, 8'hBA);
    chk("t1_last_byte", last_byte, 8'hAD);
    chk("t1_busy_low", busy, 0);

    // five not-ready polls before digest_valid
    run(5, 32'h0, 0, -1, -1);
    chk("t2_status_reads", poll_count - poll_base, 6);
    chk("t2_bytes", exp_idx, 32);
    chk("t2_done", n_done, 1);

    // slow uart plus a start pulse while busy
    run(0, 32'h0, 87, -1, 500);
    chk("t3_bytes", exp_idx, 32);
    chk("t3_done", n_done, 1);
    chk("t3_err", n_err, 0);
    chk("t3_digest_reads", dig_count - dig_base, 8);

    // never valid: timeout after 16 polls
    run(1000, 32'hFFFF_FFFD, 0, -1, -1);
    chk("t4_err", n_err, 1);
    chk("t4_done", n_done, 0);
    chk("t4_status_reads", poll_count - poll_base, 16);
    chk("t4_bytes", exp_idx, 0);
    chk("t4_busy_low", busy, 0);

    // access error on digest word 3
    run(0, 32'h0, 0, 3, -1);
    chk("t5_err", n_err, 1);
    chk("t5_done", n_done, 0);
    chk("t5_bytes", exp_idx, 12);
    chk("t5_digest_reads", dig_count - dig_base, 4);
    chk("t5_cs_low", bus.sha_cs, 0);

    // reset after byte 10, then a fresh full run
    valid_after = 0; stat_idle = 32'h0; hold = 0; err_word = -1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int i = 0; i < 2000 && exp_idx < 10; i++) @(negedge clk);
    chk("t6_reached_byte10", exp_idx, 10);
    @(posedge clk); #1 reset_n = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("t6_bytes_before_reset", exp_idx, 10);
    chk("t6_no_done", n_done, 0);
    run(0, 32'h0, 0, -1, -1);
    chk("t6_bytes", exp_idx, 32);
    chk("t6_done", n_done, 1);
    chk("t6_first_byte", first_byte, 8'hBA);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sha_digest_streamer.md
Name: sha_digest_streamer

Overview:
Reader side of the SHA-256 register interface; drains the hash result back to the host. After the block writer signals a completed block, it polls the sha256 core's status register until the digest is valid. It then reads the eight digest words and streams the 32 bytes, MSB first, through the uart_tx byte handshake. It sits between the sha256 core and uart_tx and replaces all digest/SENDING logic in the top level.

Parameters:
ADDR_STATUS, 8'h09, sha256 status register address; bit 1 = digest_valid
ADDR_DIGEST0, 8'h20, address of digest word 0; words 0..7 occupy ADDR_DIGEST0..ADDR_DIGEST0+7
POLL_TIMEOUT, 1_000_000, maximum status polls before aborting; counter width is $clog2(POLL_TIMEOUT+1)

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous reset, active low
start  in  1  one-cycle pulse: block written and hashing started
busy  out  1  high from the cycle after an accepted start until done or err
done  out  1  one-cycle pulse after the 32nd byte is accepted by uart_tx
err  out  1  one-cycle pulse on timeout or sha_error abort
sha_cs  out  1  sha256 chip select
sha_we  out  1  sha256 write enable; this block drives 0 at all times
sha_address  out  8  sha256 register address
sha_write_data  out  32  constant 0
sha_read_data  in  32  sha256 read data; combinational while cs=1 and we=0
sha_error  in  1  sha256 access error, valid in the same cycle as cs
tx_data  out  8  byte to transmit
tx_send  out  1  one-cycle send strobe to uart_tx
tx_ready  in  1  uart_tx idle; deasserts no later than 1 cycle after send is sampled

Behaviour:
- Reset (reset_n=0 at posedge): state IDLE; busy, done, err, sha_cs, tx_send = 0; sha_address = 0; tx_data = 0; word, byte and poll counters = 0. A reset mid-stream abandons the stream with no resume; tx_send is never left high.
- FSM states: IDLE, POLL, READ, SEND, HOLD, WAITTX, FIN.
- IDLE: start=1 -> POLL with busy=1. A start pulse while busy is ignored, with no queueing.
- POLL: sha_cs=1 and sha_address=ADDR_STATUS for exactly one cycle. read_data and sha_error are sampled at the end of that cycle.
  - If bit 1 is set: go to READ with word=0.
  - Otherwise increment the poll counter and stay in POLL. Back-to-back polls are allowed, so cs may stay high.
  - If the poll counter reaches POLL_TIMEOUT: pulse err, go to IDLE.
- READ: sha_cs=1 and sha_address=ADDR_DIGEST0+word for one cycle. The word is captured into a 32-bit shift register, byte=0, then go to SEND.
- SEND: wait for tx_ready=1. In that cycle tx_data = shift[31:24] and tx_send=1 for exactly that cycle, the shift register shifts left by 8, then go to HOLD.
- HOLD: one guard cycle with tx_ready ignored, then go to WAITTX.
- WAITTX: wait for tx_ready=1, then:
  - if byte<3: byte+1, go to SEND;
  - else if word<7: word+1, go to READ;
  - else go to FIN.
- FIN: done=1 for one cycle, busy=0 in the following cycle, go to IDLE.
- sha_error=1 in any cs cycle: abort. Pulse err, drop cs, go to IDLE, and send no further bytes. Bytes already sent stand.
- sha_cs is 0 in every state except POLL and READ. tx_data holds its last value while tx_send=0.
- Output order: digest word 0 byte[31:24] first, word 7 byte[7:0] last, for 32 bytes in total.
- Minimum latency from start to the first tx_send is 3 cycles (POLL, READ, SEND), given digest_valid on the first poll and tx_ready=1.
- done and err are mutually exclusive and never asserted in the same transaction.

Decomposition:
- Shared package sha_if_pkg holds:
  - sha256 register address constants (ADDR_CTRL, ADDR_STATUS, ADDR_BLOCK0, ADDR_DIGEST0);
  - status bit indices (STATUS_READY_BIT=0, STATUS_VALID_BIT=1);
  - the FSM state encoding localparams.
- No sub-module is needed. The byte serializer (shift register plus byte counter) stays inline because it is under 30 lines.

Test Plan:
- Digest of "abc" ready on the first poll, tx_ready always 1 -> 32 tx_send pulses with bytes BA 78 16 BF ... F2 00 15 AD, then done one cycle after the last byte is accepted, no err.
- Status reads 0 for 5 polls, then 2 -> exactly 6 status reads before the first digest read; stream is correct.
- uart_tx model holds tx_ready low 87 cycles per byte -> each tx_send exactly one cycle, never asserted while tx_ready=0, and 32 bytes in order.
- POLL_TIMEOUT=16, status never valid -> err after 16 polls, busy low, zero tx_send pulses.
- sha_error=1 on the digest word 3 read -> err pulse, exactly 12 bytes sent, cs low afterwards.
- Assert reset_n=0 for one cycle after byte 10, then issue a new start -> outputs zero in the cycle after reset; the new run emits the full 32 bytes starting at word 0.
